clk_div_gen: RTL

Parametrised, multi-channel programmable clock-enable generator; the successor to the single free-running divider counter. It provides N_CH independent tick channels with run-time writable divisors, glitch-free ratio changes, square-wave phase outputs and a free-running timebase counter. It sits beside the display and scan logic, which consume its ticks as clock enables. It never drives a derived clock.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 92 +++++++++
 rtl/clk_div_gen.sv | 69 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-enable generator.
// Holds the default parameter values used by clk_div_gen and clk_div_chan.
// Also holds the helper that sizes the channel-select port.
package clk_div_pkg;

  localparam int N_CH_DEF        = 4;
  localparam int DIV_W_DEF       = 32;
  localparam int CNT_W_DEF       = 32;
  localparam int DEFAULT_DIV_DEF = 100000;

  // Width of the channel-select port. A single-channel build still
  // gets a 1-bit select, so the port is never zero width.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One tick channel of the clock-enable generator.
// Ports:
//   clk       system clock (rising edge)
//   rst       synchronous active-low reset
//   en        run enable
//   sync_clr  restart the counter from the active divisor
//   we        write strobe, already decoded for this channel
//   wr_val    divisor being written (0 disables the channel)
//   tick      registered one-cycle pulse at terminal count
//   phase     registered square wave, toggles on every tick
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             we,
  input  logic [DIV_W-1:0] wr_val,
  output logic             tick,
  output logic             phase
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_CNT  = DIV_W'(DEFAULT_DIV - 1);

  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] act_reg, act_next;
  logic [DIV_W-1:0] shd_reg, shd_next;
  logic             tick_reg, tick_next;
  logic             phase_reg, phase_next;
  logic [DIV_W-1:0] shd_eff;

  always_comb begin
    // A write landing on the terminal-count edge must feed the reload.
    shd_eff    = we ? wr_val : shd_reg;
    cnt_next   = cnt_reg;
    act_next   = act_reg;
    shd_next   = shd_eff;
    tick_next  = 1'b0;
    phase_next = phase_reg;

    if (act_reg == '0) begin
      // Disabled: a non-zero write restarts the channel immediately.
      phase_next = 1'b0;
      if (we && (wr_val != '0)) begin
        act_next = wr_val;
        cnt_next = wr_val - ONE;
      end
    end else if (sync_clr) begin
      cnt_next   = act_reg - ONE;
      phase_next = 1'b0;
    end else if (!en) begin
      // Freeze count and phase; tick stays low.
    end else if (cnt_reg == '0) begin
      tick_next  = 1'b1;
      phase_next = ~phase_reg;
      act_next   = shd_eff;
      // Reloading from zero would underflow; the channel simply
      // becomes disabled with its counter left where it is.
      if (shd_eff != '0) begin
        cnt_next = shd_eff - ONE;
      end
    end else begin
      cnt_next = cnt_reg - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg   <= RST_CNT;
      act_reg   <= RST_DIV;
      shd_reg   <= RST_DIV;
      tick_reg  <= 1'b0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
      shd_reg   <= shd_next;
      tick_reg  <= tick_next;
      phase_reg <= phase_next;
    end
  end

  assign tick  = tick_reg;
  assign phase = phase_reg;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock-enable generator.
// Ports:
//   clk       system clock (rising edge)
//   rst       synchronous active-low reset
//   en        global run enable for all channels
//   sync_clr  restart every channel counter
//   div_we    divisor write strobe
//   div_sel   channel addressed by the write (out-of-range ignored)
//   div_val   new divisor, 0 disables the channel
//   tick      per-channel one-cycle clock-enable pulses
//   phase     per-channel square waves (period 2 x divisor)
//   free_cnt  free-running cycle counter, wraps
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int  N_CH        = N_CH_DEF,
  parameter int  DIV_W       = DIV_W_DEF,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int SEL_W       = sel_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_val,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  phase,
  output logic [CNT_W-1:0] free_cnt
);

  logic [N_CH-1:0]  we_ch;
  logic [CNT_W-1:0] free_cnt_reg;

  // Select values at or above N_CH match no channel, so such
  // writes fall through without any extra range check.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign we_ch[gi] = div_we && (div_sel == SEL_W'(gi));

      clk_div_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .we       (we_ch[gi]),
        .wr_val   (div_val),
        .tick     (tick[gi]),
        .phase    (phase[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      free_cnt_reg <= '0;
    end else begin
      free_cnt_reg <= free_cnt_reg + CNT_W'(1);
    end
  end

  assign free_cnt = free_cnt_reg;

endmodule
